dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Parametrised N-way set-associative write-back, write-allocate data cache for the MEM stage.
//  Hits complete combinationally in the access cycle; misses stall the pipeline.
//  During a stall an FSM evicts the dirty victim, then refills from a req/ack backing-memory port.
//  Replaces fixed two-level L1/L2 wiring; the backing port connects to an L2 or to main data memory.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width
//  SETS        64  number of sets, power of 2, >=2
//  WAYS        2   associativity, power of 2, 1..8
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  req_valid  in   1   MEM-stage access this cycle (load or store)
//  we         in   1   1 = store, 0 = load
//  addr       in   AW  byte address
//  wdata      in   32  store data (rs2)
//  funct3     in   3   RV32 load/store width code
//  rdata      out  32  load result, extended per funct3
//  hit        out  1   access hits a valid way (combinational)
//  stall      out  1   hold pipeline: req_valid & ~hit, or FSM not IDLE
//  mem_req    out  1   backing request, held until mem_ack
//  mem_we     out  1   1 = writeback, 0 = refill read
//  mem_addr   out  AW  word-aligned backing address
//  mem_wdata  out  32  victim data on writeback
//  mem_ack    in   1   backing request complete; mem_rdata valid this cycle on a read
//  mem_rdata  in   32  refill data
// BEHAVIOUR
//  - Line = one 32-bit word. Address split: [1:0] byte offset, next log2(SETS) bits index, rest tag.
//  - Per way/set: valid, dirty, tag, data. Victim select: lowest invalid way, else the per-set
//    round-robin pointer. The pointer increments mod WAYS on every refill of that set.
//  - Hit, load: rdata is valid in the same cycle and stall=0. Extension by funct3:
//    000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero.
//    Byte lane = addr[1:0]; half lane = addr[1]. addr[0] is ignored for halfwords; no misalign trap.
//  - Hit, store: byte enables from funct3 (000 SB, 001 SH, 010 SW). Data written and dirty set at
//    the next posedge.
//  - FSM states: IDLE, WB, REFILL.
//    IDLE->WB: on req_valid & ~hit when the victim is valid & dirty.
//    IDLE->REFILL: on req_valid & ~hit otherwise.
//    WB->REFILL: on mem_ack.
//    REFILL->IDLE: on mem_ack, after writing mem_rdata into the victim way (valid=1, dirty=0,
//    new tag).
//  - The retried access hits in IDLE the cycle after REFILL. A store then merges and sets dirty.
//    Miss penalty is therefore 1 cycle plus backing latency (plus WB latency if the victim is dirty).
//  - Handshake: mem_req rises the cycle after entering WB/REFILL and stays high, with
//    mem_addr/mem_we/mem_wdata stable, until the cycle mem_ack=1. The cycle after ack it drops for at
//    least 1 cycle. mem_ack while mem_req=0 is ignored.
//  - stall is combinational, so pipeline inputs stay stable while stalled. req_valid=0 in IDLE
//    gives stall=0 and hit=0.
//  - Reset: all valid/dirty/pointers = 0, FSM = IDLE. Outputs are rdata=0, hit=0, stall=0,
//    mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
//  - Reset mid-miss aborts the transaction: mem_req=0 the next cycle and dirty data is discarded.
//  - Simultaneous rst and mem_ack: rst wins.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
//    Each counts at most once per access: a hit increments hit_cnt at the access posedge; a miss
//    increments miss_cnt on IDLE->WB/REFILL.
//    The retry hit after a refill is not counted. Counters wrap at 2^32-1 -> 0 and clear on rst.
//  Undefined: no counters and no extra ports; behaviour otherwise identical.
// TESTING
//  1 Cold LW 0x100, mem_rdata=0xDEADBEEF, ack after 3 cycles -> one refill (mem_we=0,
//    mem_addr=0x100); then hit, rdata=0xDEADBEEF, stall=0.
//  2 Refill 0x80 with 0x000080F0, then LB 0x80 -> 0xFFFFFFF0; LBU 0x80 -> 0x000000F0;
//    LH 0x82 -> 0x00000000; LHU 0x80 -> 0x000080F0.
//  3 SW 0x200=0x11223344, then SB 0x201=0xAA -> LW 0x200 = 0x1122AA44;
//    no mem_req after the initial refill.
//  4 WAYS=2: dirty 0x000, 0x100, 0x200 in the same set (SETS=64) -> access 0x200 writes back
//    0x000's data (mem_we=1) before its refill.
//  5 rst asserted while in REFILL with mem_req=1 -> next cycle mem_req=0, stall=0;
//    LW 0x100 misses again.
//  6 DCACHE_STATS_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2;
//    preset hit_cnt=0xFFFFFFFF then 1 hit -> 0.

Source files
------------

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - N-way set-associative write-back data cache controller (optional DCACHE_STATS_EN counters)
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [2:0]            funct3,
  output logic [31:0]           rdata,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WB     = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;

  logic [1:0]       state;
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]      data_q  [SETS][WAYS];
  logic [WAY_W-1:0] ptr_q   [SETS];
  logic [WAY_W-1:0] victim_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic [31:0]      word;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      load_ext;
  logic [3:0]       be;
  logic [31:0]      wlane;
  logic [31:0]      merged;
  logic             miss_start;
  logic             wb_done;
  logic             refill_done;

  assign idx = addr[2 +: IDX_W];
  assign tag = addr[ADDR_WIDTH-1 -: TAG_W];

  // Tag compare across ways; victim is the lowest invalid way, else the set's round-robin pointer
  always_comb begin
    hit_any    = 1'b0;
    hit_way    = '0;
    victim_way = ptr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        victim_way = WAY_W'(w);
      end
    end
  end

  assign word  = data_q[idx][hit_way];
  assign hit   = req_valid && (state == S_IDLE) && hit_any;
  assign stall = (req_valid && !hit) || (state != S_IDLE);

  // Load lane select and sign/zero extension; addr[0] is ignored for halfwords
  always_comb begin
    lane_b = word[{addr[1:0], 3'b000} +: 8];
    lane_h = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'd0, lane_b};
      3'b101:  load_ext = {16'd0, lane_h};
      default: load_ext = word;
    endcase
    rdata = hit ? load_ext : 32'd0;
  end

  // Store byte enables and merge of replicated store data into the hit word
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata;
      end
    endcase
    merged = word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = wlane[8*b +: 8];
    end
  end

  assign miss_start  = (state == S_IDLE) && req_valid && !hit_any;
  assign wb_done     = (state == S_WB) && mem_req && mem_ack;
  assign refill_done = (state == S_REFILL) && mem_req && mem_ack;

  // Miss FSM and backing-port request register; request drops for a cycle after every ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      victim_q  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss_start) begin
            victim_q <= victim_way;
            state    <= (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) ? S_WB : S_REFILL;
          end
        end
        S_WB:     if (wb_done) state <= S_REFILL;
        S_REFILL: if (refill_done) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
      end else if (!mem_req && (state == S_WB)) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= {tag_q[idx][victim_q], idx, 2'b00};
        mem_wdata <= data_q[idx][victim_q];
      end else if (!mem_req && (state == S_REFILL)) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
      end
    end
  end

  // Line state: refill installs a clean valid line and advances the set pointer; store hits mark dirty
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (refill_done) begin
      valid_q[idx][victim_q] <= 1'b1;
      dirty_q[idx][victim_q] <= 1'b0;
      ptr_q[idx] <= (ptr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[idx] + 1'b1;
    end else if (hit && we) begin
      dirty_q[idx][hit_way] <= 1'b1;
    end
  end

  // Tag and data storage, not reset since valid bits qualify them
  always_ff @(posedge clk) begin
    if (!rst && refill_done) begin
      tag_q[idx][victim_q]  <= tag;
      data_q[idx][victim_q] <= mem_rdata;
    end else if (!rst && hit && we) begin
      data_q[idx][hit_way] <= merged;
    end
  end

`ifdef DCACHE_STATS_EN
  logic retry_q;

  // Access counters; the retry hit right after a refill belongs to the miss already counted
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      retry_q  <= 1'b0;
    end else begin
      retry_q <= refill_done;
      if (hit && !retry_q) hit_cnt <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized self-checking bench for dcache_ctrl against a word-level cache model
module tb_dcache_ctrl;
  localparam int SETS = 64;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  dcache_ctrl #(.ADDR_WIDTH(32), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .rdata(rdata), .hit(hit), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: each resident line is identified by its full word address
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [31:0] m_line  [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS];
  int          m_ptr   [SETS];
  logic [31:0] mem_model [int unsigned];
  int          exp_hits;
  int          exp_misses;
  int          wb_count;
  int          refill_count;
  logic [31:0] last_wb_addr;

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] a,
                                              input logic [2:0] f, input logic [31:0] d);
    logic [31:0] r;
    int n;
    int lo;
    r  = old;
    n  = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
    lo = (f == 3'd0) ? int'(a % 4) : (f == 3'd1) ? int'(2 * ((a / 2) % 2)) : 0;
    for (int i = 0; i < n; i++) r[8*(lo+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset;
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = 1'b0; we = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One MEM-stage access, serving the backing port until the retry completes; entered 1 time unit after a posedge
  task automatic do_access(input logic w, input logic [31:0] a, input logic [2:0] f,
                           input logic [31:0] d, input int lat, output logic [31:0] obs);
    int s, way, v, phase, waits, guard, l;
    logic [31:0] wa, ea;
    bit timed_out;
    wa = a >> 2;
    s = int'(wa % SETS);
    way = -1;
    l = 0;
    timed_out = 1'b0;
    obs = 32'd0;
    for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_line[s][i] == wa) way = i;
    req_valid = 1'b1; we = w; addr = a; funct3 = f; wdata = d;
    @(negedge clk);
    checks++; if (hit !== (way >= 0)) begin failures++; $display("FAIL hit a=%h: got %b expected %b", a, hit, way >= 0); end
    checks++; if (stall !== (way < 0)) begin failures++; $display("FAIL stall a=%h: got %b expected %b", a, stall, way < 0); end
    if (way < 0) begin
      exp_misses++;
      v = -1;
      for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) v = i;
      if (v < 0) v = m_ptr[s];
      phase = (m_valid[s][v] && m_dirty[s][v]) ? 1 : 2;
      waits = 0;
      guard = 0;
      while (phase != 0) begin
        if (guard >= 100) begin
          checks++; failures++;
          $display("FAIL miss_timeout a=%h: got no completion expected completion within 100 cycles", a);
          timed_out = 1'b1;
          break;
        end
        guard++;
        if (mem_req === 1'b1) begin
          if (waits == 0) begin
            l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            ea = (phase == 1) ? (m_line[s][v] << 2) : (wa << 2);
            checks++; if (mem_we !== (phase == 1)) begin failures++; $display("FAIL mem_we: got %b expected %b", mem_we, phase == 1); end
            checks++; if (mem_addr !== ea) begin failures++; $display("FAIL mem_addr: got %h expected %h", mem_addr, ea); end
            if (phase == 1) begin
              checks++; if (mem_wdata !== m_data[s][v]) begin failures++; $display("FAIL mem_wdata: got %h expected %h", mem_wdata, m_data[s][v]); end
            end
          end
          if (waits >= l) begin
            mem_ack = 1'b1;
            if (phase == 1) begin
              mem_model[m_line[s][v]] = m_data[s][v];
              last_wb_addr = m_line[s][v] << 2;
              wb_count++;
              phase = 2;
            end else begin
              if (!mem_model.exists(wa)) mem_model[wa] = $urandom;
              mem_rdata = mem_model[wa];
              refill_count++;
              phase = 0;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            waits = 0;
            if (phase != 0) begin
              @(negedge clk);
              checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL req_gap: got %b expected 0", mem_req); end
            end
          end else begin
            waits++;
            @(negedge clk);
          end
        end else begin
          @(negedge clk);
        end
      end
      if (!timed_out) begin
        m_valid[s][v] = 1'b1;
        m_dirty[s][v] = 1'b0;
        m_line[s][v] = wa;
        m_data[s][v] = mem_model[wa];
        m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        way = v;
        @(negedge clk);
        checks++; if (hit !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL retry_hit a=%h: got hit=%b stall=%b expected hit=1 stall=0", a, hit, stall); end
      end
    end else begin
      exp_hits++;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hit_no_req: got %b expected 0", mem_req); end
    end
    if (!timed_out) begin
      obs = rdata;
      if (!w) begin
        checks++; if (rdata !== load_val(m_data[s][way], a, f)) begin failures++; $display("FAIL rdata a=%h f=%0d: got %h expected %h", a, f, rdata, load_val(m_data[s][way], a, f)); end
      end else begin
        m_data[s][way] = store_merge(m_data[s][way], a, f, d);
        m_dirty[s][way] = 1'b1;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; we = 1'b0; mem_ack = 1'b0;
    addr = 32'd0; wdata = 32'd0; funct3 = 3'd0; mem_rdata = 32'd0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    checks++; if (hit !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_hit_stall: got %b%b expected 00", hit, stall); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_req_we: got %b%b expected 00", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin failures++; $display("FAIL rst_addr_wdata: got %h %h expected 0 0", mem_addr, mem_wdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_cold_load;
    logic [31:0] obs;
    int r0;
    mem_model[32'h100 >> 2] = 32'hDEADBEEF;
    r0 = refill_count;
    do_access(1'b0, 32'h100, 3'b010, 32'd0, 3, obs);
    checks++; if (obs !== 32'hDEADBEEF) begin failures++; $display("FAIL cold_lw: got %h expected deadbeef", obs); end
    do_access(1'b0, 32'h100, 3'b010, 32'd0, 0, obs);
    checks++; if (refill_count - r0 !== 1) begin failures++; $display("FAIL cold_refills: got %0d expected 1", refill_count - r0); end
  endtask

  task automatic test_load_ext;
    logic [31:0] obs;
    mem_model[32'h80 >> 2] = 32'h000080F0;
    do_access(1'b0, 32'h80, 3'b010, 32'd0, 1, obs);
    do_access(1'b0, 32'h80, 3'b000, 32'd0, 0, obs);
    checks++; if (obs !== 32'hFFFFFFF0) begin failures++; $display("FAIL lb: got %h expected fffffff0", obs); end
    do_access(1'b0, 32'h80, 3'b100, 32'd0, 0, obs);
    checks++; if (obs !== 32'h000000F0) begin failures++; $display("FAIL lbu: got %h expected 000000f0", obs); end
    do_access(1'b0, 32'h82, 3'b001, 32'd0, 0, obs);
    checks++; if (obs !== 32'h00000000) begin failures++; $display("FAIL lh: got %h expected 00000000", obs); end
    do_access(1'b0, 32'h80, 3'b101, 32'd0, 0, obs);
    checks++; if (obs !== 32'h000080F0) begin failures++; $display("FAIL lhu: got %h expected 000080f0", obs); end
  endtask

  task automatic test_store_merge;
    logic [31:0] obs;
    int r0;
    r0 = refill_count;
    do_access(1'b1, 32'h200, 3'b010, 32'h11223344, 2, obs);
    do_access(1'b1, 32'h201, 3'b000, 32'h000000AA, 0, obs);
    do_access(1'b0, 32'h200, 3'b010, 32'd0, 0, obs);
    checks++; if (obs !== 32'h1122AA44) begin failures++; $display("FAIL store_merge: got %h expected 1122aa44", obs); end
    checks++; if (refill_count - r0 !== 1) begin failures++; $display("FAIL store_refills: got %0d expected 1", refill_count - r0); end
  endtask

  task automatic test_dirty_evict;
    logic [31:0] obs;
    int w0;
    do_reset();
    do_access(1'b1, 32'h000, 3'b010, 32'hA0A0A0A0, 1, obs);
    do_access(1'b1, 32'h100, 3'b010, 32'hB1B1B1B1, 1, obs);
    w0 = wb_count;
    do_access(1'b0, 32'h200, 3'b010, 32'd0, 2, obs);
    checks++; if (wb_count - w0 !== 1 || last_wb_addr !== 32'h000) begin failures++; $display("FAIL evict: got wbs=%0d addr=%h expected wbs=1 addr=00000000", wb_count - w0, last_wb_addr); end
    checks++; if (mem_model[0] !== 32'hA0A0A0A0) begin failures++; $display("FAIL evict_data: got %h expected a0a0a0a0", mem_model[0]); end
  endtask

  task automatic test_reset_mid_miss;
    logic [31:0] obs;
    int g;
    do_reset();
    req_valid = 1'b1; we = 1'b0; addr = 32'h100; funct3 = 3'b010;
    g = 0;
    @(negedge clk);
    while (mem_req !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL mid_req: got req=%b we=%b expected req=1 we=0", mem_req, mem_we); end
    rst = 1'b1; req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55555555;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL mid_rst: got req=%b stall=%b expected 0 0", mem_req, stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    do_access(1'b0, 32'h100, 3'b010, 32'd0, 1, obs);
    checks++; if (obs !== 32'hDEADBEEF) begin failures++; $display("FAIL post_rst_lw: got %h expected deadbeef", obs); end
  endtask

  task automatic test_stray_ack;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL stray_ack: got req=%b stall=%b expected 0 0", mem_req, stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [31:0] obs, a;
    logic [2:0] f;
    logic w;
    for (int n = 0; n < 300; n++) begin
      a = ((($urandom_range(0, 3) * SETS) + $urandom_range(0, 3)) << 2) | $urandom_range(0, 3);
      w = $urandom_range(0, 2) == 0;
      if (w) f = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f = 3'd0; 1: f = 3'd1; 2: f = 3'd2; 3: f = 3'd4; default: f = 3'd5;
        endcase
      end
      do_access(w, a, f, $urandom, -1, obs);
    end
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    checks++; if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin failures++; $display("FAIL rand_stats: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses); end
    @(posedge clk); #1;
`endif
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats;
    logic [31:0] obs;
    do_reset();
    do_access(1'b0, 32'h40, 3'b010, 32'd0, 1, obs);
    do_access(1'b0, 32'h44, 3'b010, 32'd0, 1, obs);
    do_access(1'b0, 32'h40, 3'b010, 32'd0, 0, obs);
    do_access(1'b0, 32'h44, 3'b010, 32'd0, 0, obs);
    do_access(1'b0, 32'h40, 3'b010, 32'd0, 0, obs);
    @(negedge clk);
    checks++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2) begin failures++; $display("FAIL stats: got %0d/%0d expected 3/2", hit_cnt, miss_cnt); end
    dut.hit_cnt = 32'hFFFFFFFF;
    @(posedge clk); #1;
    do_access(1'b0, 32'h40, 3'b010, 32'd0, 0, obs);
    @(negedge clk);
    checks++; if (hit_cnt !== 32'd0) begin failures++; $display("FAIL stats_wrap: got %h expected 0", hit_cnt); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    wb_count = 0;
    refill_count = 0;
    last_wb_addr = 32'd0;
    test_reset();
    test_cold_load();
    test_load_ext();
    test_store_merge();
    test_stray_ack();
    test_dirty_evict();
    test_reset_mid_miss();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
